// File: rtl/elastic_pipereg.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides,
// synchronous flush and occupancy count. Define ELASTIC_PIPEREG_FULL_THRU_EN to allow push into a full buffer during a pop.
module elastic_pipereg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths index correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? storage[rd_ptr] : '0;

`ifdef ELASTIC_PIPEREG_FULL_THRU_EN
    assign in_ready = ((count < FULL_CNT) || out_ready) && !flush;
`else
    assign in_ready = (count < FULL_CNT) && !flush;
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately left unreset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[wr_ptr] <= in_data;
        end
    end

endmodule
